// File: rtl/apb_mstr_bridge_pkg.sv
// Purpose : shared types for the APB master bridge (FSM states, command/response bundles).
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: state_e, cmd_t, rsp_t, SEL_IDX_WIDTH, sel_in_range().
package apb_mstr_bridge_pkg;

  localparam int SEL_IDX_WIDTH = 4;

  // Bundle field widths; sized for the default 32-bit APB bus.
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic                     write;
    logic [BUS_ADDR_W-1:0]    addr;
    logic [BUS_DATA_W-1:0]    wdata;
    logic [SEL_IDX_WIDTH-1:0] sel;
  } cmd_t;

  typedef struct packed {
    logic [BUS_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  // A select index outside the populated psel lines is a decode error.
  function automatic logic sel_in_range(input logic [SEL_IDX_WIDTH-1:0] sel,
                                        input int num_slv);
    return int'(sel) < num_slv;
  endfunction

endpackage

// File: rtl/apb_mstr_bridge_wdog.sv
// Purpose : ACCESS-phase wait counter; pulses expired on the last permitted wait cycle.
// Latency : expired is combinational from the counter and en (same cycle).
// Backpr. : none; counter saturates at the limit and never wraps.
// Ports   : clk, reset_n (sync, active-low), clr (zero the count), en (count one wait), expired.
module apb_mstr_bridge_wdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      // Timeout disabled: no counter, inputs deliberately unused.
      logic unused_wdog;
      assign unused_wdog = ^{clk, reset_n, clr, en};
      assign expired     = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] cnt;

      // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle.
      assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en && !expired) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/apb_mstr_bridge.sv
// Purpose : single-outstanding APB3 master; cmd valid/ready stream in, rsp valid/ready stream out.
// Latency : cmd accepted at N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3 (+1 per wait state);
//           decode error -> rsp_valid at N+1.
// Backpr. : cmd_ready only in IDLE; rsp_valid holds with stable data until rsp_ready.
// Ports   : clk, reset_n; cmd_{valid,ready,write,addr,wdata,sel}; rsp_{valid,ready,rdata,err,timeout};
//           APB paddr, psel, penable, pwrite, pwdata, pready, prdata, pslverr.
module apb_mstr_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLV        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [NUM_SLV-1:0]    psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  import apb_mstr_bridge_pkg::*;

  state_e state;
  cmd_t   cmd_in;
  rsp_t   rsp_q;
  logic   cmd_fire;
  logic   sel_ok;
  logic   wd_clr;
  logic   wd_en;
  logic   wd_expired;

  assign cmd_in = '{write: cmd_write,
                    addr:  BUS_ADDR_W'(cmd_addr),
                    wdata: BUS_DATA_W'(cmd_wdata),
                    sel:   cmd_sel};

  // Gated with reset_n so the requester sees no acceptance while reset is held.
  assign cmd_ready = reset_n && (state == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign sel_ok    = sel_in_range(cmd_in.sel, NUM_SLV);

  // Counter zeroes during SETUP so it starts fresh on ACCESS entry.
  assign wd_clr = (state == SETUP);
  assign wd_en  = (state == ACCESS) && !pready;

  apb_mstr_bridge_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  assign rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      psel      <= '0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (sel_ok) begin
              // The APB output registers double as the latched command.
              state  <= SETUP;
              psel   <= NUM_SLV'(1) << cmd_in.sel;
              paddr  <= ADDR_WIDTH'(cmd_in.addr);
              pwrite <= cmd_in.write;
              pwdata <= cmd_in.write ? DATA_WIDTH'(cmd_in.wdata) : '0;
            end else begin
              // Decode error: answer without touching the bus.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_q     <= '{rdata: '0, err: 1'b1, timeout: 1'b0};
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          // pready wins over a simultaneous expiry.
          if (pready) begin
            state     <= RESP;
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_q     <= '{rdata:   pwrite ? '0 : BUS_DATA_W'(prdata),
                           err:     pslverr,
                           timeout: 1'b0};
          end else if (wd_expired) begin
            state     <= RESP;
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_q     <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mstr_bridge.sv
// Purpose : directed bench for apb_mstr_bridge (NUM_SLV=4, TIMEOUT_CYCLES=8).
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpr. : exercises held rsp_ready=0 with a pending command.
module tb_apb_mstr_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  always #5 clk = ~clk;

  apb_mstr_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLV(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        write;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;       // wait cycles before pready; >= 8 means never
    logic [31:0] prdata;
    logic        pslverr;
    logic [3:0]  exp_psel;
    logic [31:0] exp_pwdata;
    int          exp_access;  // ACCESS cycles (penable high); 0 for decode error
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  vec_t vecs[8];

  // Drives one command from IDLE through the response handshake; ends on a falling edge in IDLE.
  task automatic run_txn(input int idx, input vec_t v);
    int acc;
    chk($sformatf("v%0d cmd_ready_idle", idx), cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_sel   = v.sel;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    pready    = 1'b0;
    step();                                   // N+1
    cmd_valid = 1'b0;
    chk($sformatf("v%0d psel_setup", idx), psel, v.exp_psel);
    acc = 0;
    if (v.exp_access != 0) begin
      chk($sformatf("v%0d penable_setup", idx), penable, 1'b0);
      chk($sformatf("v%0d paddr", idx), paddr, v.addr);
      chk($sformatf("v%0d pwrite", idx), pwrite, v.write);
      chk($sformatf("v%0d pwdata", idx), pwdata, v.exp_pwdata);
      step();                                 // N+2, first ACCESS cycle
      for (int i = 0; i < 20 && penable === 1'b1; i++) begin
        acc++;
        if (psel !== v.exp_psel) chk($sformatf("v%0d psel_access", idx), psel, v.exp_psel);
        pready  = (acc == v.waits + 1);
        prdata  = pready ? v.prdata : 32'h1111_1111;
        pslverr = pready ? v.pslverr : 1'b0;
        step();
      end
      pready  = 1'b0;
      pslverr = 1'b0;
    end
    chk($sformatf("v%0d access_cycles", idx), acc, v.exp_access);
    chk($sformatf("v%0d psel_resp", idx), psel, 4'b0000);
    chk($sformatf("v%0d penable_resp", idx), penable, 1'b0);
    chk($sformatf("v%0d rsp_valid", idx), rsp_valid, 1'b1);
    chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
    chk($sformatf("v%0d rsp_timeout", idx), rsp_timeout, v.exp_to);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk($sformatf("v%0d rsp_valid_clr", idx), rsp_valid, 1'b0);
    chk($sformatf("v%0d cmd_ready_back", idx), cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    //          wr    sel   addr          wdata         w   prdata        err   psel     pwdata        acc rdata         err   to
    vecs[0] = '{1'b1, 4'd2, 32'h0000_1000, 32'hDEAD_BEEF, 0,  32'h0000_0000, 1'b0, 4'b0100, 32'hDEAD_BEEF, 1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'd0, 32'h0000_0020, 32'h1234_5678, 3,  32'hA5A5_0001, 1'b1, 4'b0001, 32'h0000_0000, 4, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'd7, 32'h0000_0040, 32'h5555_AAAA, 0,  32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 4'd1, 32'h0000_2000, 32'h0000_0000, 99, 32'hFFFF_0000, 1'b0, 4'b0010, 32'h0000_0000, 8, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 4'd3, 32'h0000_3004, 32'h0000_0000, 7,  32'h0BAD_CAFE, 1'b0, 4'b1000, 32'h0000_0000, 8, 32'h0BAD_CAFE, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'd3, 32'h0000_0ABC, 32'h0102_0304, 2,  32'hFFFF_FFFF, 1'b1, 4'b1000, 32'h0102_0304, 3, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 4'd1, 32'h0000_0010, 32'h9999_9999, 0,  32'h0000_5A5A, 1'b0, 4'b0010, 32'h0000_0000, 1, 32'h0000_5A5A, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 4'd4, 32'h0000_0080, 32'h0000_0000, 0,  32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1'b0};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;

    // Reset state
    step(); step(); step();
    chk("rst cmd_ready", cmd_ready, 1'b0);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst psel", psel, 4'b0000);
    chk("rst penable", penable, 1'b0);
    chk("rst paddr", paddr, 32'h0);
    chk("rst pwdata", pwdata, 32'h0);
    chk("rst rsp_err", rsp_err, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("rst release cmd_ready", cmd_ready, 1'b1);
    step();

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

    // Response backpressure with a second command waiting.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_sel = 4'd1; cmd_addr = 32'h44; cmd_wdata = 32'h0;
    pready = 1'b1; prdata = 32'h0000_0077; pslverr = 1'b0;
    step();                                   // SETUP of first
    cmd_write = 1'b1; cmd_sel = 4'd2; cmd_addr = 32'h88; cmd_wdata = 32'h0000_CAFE;
    chk("bp psel_first", psel, 4'b0010);
    step();                                   // ACCESS of first
    step();                                   // RESP
    pready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d rsp_valid", i), rsp_valid, 1'b1);
      chk($sformatf("bp%0d cmd_ready", i), cmd_ready, 1'b0);
      chk($sformatf("bp%0d rsp_rdata", i), rsp_rdata, 32'h0000_0077);
      chk($sformatf("bp%0d psel", i), psel, 4'b0000);
      step();
    end
    rsp_ready = 1'b1;
    step();                                   // IDLE, second command accepted at next edge
    rsp_ready = 1'b0;
    chk("bp rsp_valid_clr", rsp_valid, 1'b0);
    chk("bp cmd_ready", cmd_ready, 1'b1);
    step();                                   // SETUP of second
    cmd_valid = 1'b0;
    chk("bp2 psel", psel, 4'b0100);
    chk("bp2 pwrite", pwrite, 1'b1);
    chk("bp2 paddr", paddr, 32'h88);
    chk("bp2 pwdata", pwdata, 32'h0000_CAFE);
    pready = 1'b1;
    step();                                   // ACCESS
    step();                                   // RESP
    pready = 1'b0;
    chk("bp2 rsp_valid", rsp_valid, 1'b1);
    chk("bp2 rsp_err", rsp_err, 1'b0);
    chk("bp2 rsp_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset during ACCESS abandons the transfer.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_sel = 4'd0; cmd_addr = 32'h100;
    step();                                   // SETUP
    cmd_valid = 1'b0;
    step();                                   // ACCESS
    chk("rstacc penable_pre", penable, 1'b1);
    reset_n = 1'b0;
    step();
    chk("rstacc psel", psel, 4'b0000);
    chk("rstacc penable", penable, 1'b0);
    chk("rstacc rsp_valid", rsp_valid, 1'b0);
    chk("rstacc cmd_ready", cmd_ready, 1'b0);
    reset_n = 1'b1;
    pready  = 1'b1;
    prdata  = 32'hBEEF_0000;
    #1;
    chk("rstacc release cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rstacc%0d no_stale_rsp", i), rsp_valid, 1'b0);
      chk($sformatf("rstacc%0d psel_idle", i), psel, 4'b0000);
    end
    pready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_mstr_bridge.md
Name: apb_mstr_bridge

Overview:
- Single-outstanding APB master bridge.
- Converts a valid/ready command stream from an on-chip requester into APB3 transfers (SETUP/ACCESS), and returns read data and error status on a valid/ready response stream.
- Sits directly upstream of the APB bus; its APB pins connect to the bus the APB agent monitors and drives.
- Provides decode error and access timeout handling.

Parameters:
- ADDR_WIDTH, 32, paddr/cmd_addr width.
- DATA_WIDTH, 32, pwdata/prdata/cmd_wdata/rsp_rdata width.
- NUM_SLV, 4, number of psel lines (1..16).
- TIMEOUT_CYCLES, 256, max ACCESS cycles waiting for pready; 0 disables the timeout.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  bridge accepts command
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_WIDTH  byte address
- cmd_wdata  input  DATA_WIDTH  write data
- cmd_sel  input  4  target slave index
- rsp_valid  output  1  response available
- rsp_ready  input  1  requester takes response
- rsp_rdata  output  DATA_WIDTH  read data (0 for writes/errors)
- rsp_err  output  1  pslverr, decode error or timeout
- rsp_timeout  output  1  error was a timeout
- paddr  output  ADDR_WIDTH  APB address
- psel  output  NUM_SLV  one-hot APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- pwdata  output  DATA_WIDTH  APB write data
- pready  input  1  APB ready
- prdata  input  DATA_WIDTH  APB read data
- pslverr  input  1  APB slave error

Behaviour:
- Interface: one clock (clk); reset (reset_n) is synchronous and active-low.
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0 except cmd_ready, which is 1 once reset_n=1.
  - Takes priority over any in-flight transfer. The transfer is abandoned: psel/penable are 0 next cycle and no response is produced.
- All outputs are registered except cmd_ready, which is decoded from state (cmd_ready = state==IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on cmd_valid && cmd_ready, latch the command.
  - If cmd_sel < NUM_SLV: go to SETUP.
  - Otherwise (decode error): go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0. No APB activity.
- SETUP (1 cycle):
  - psel[cmd_sel]=1, penable=0.
  - paddr, pwrite and pwdata hold the latched values (pwdata=0 for reads).
  - Always go to ACCESS.
- ACCESS:
  - psel held, penable=1, all APB outputs stable.
  - If pready=1: capture rsp_rdata = pwrite ? 0 : prdata, and rsp_err = pslverr. Go to RESP.
  - If pready=0: increment wait counter. When TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 with pready still 0, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 on the timeout cycle wins: normal completion.
- RESP:
  - psel=0, penable=0.
  - paddr, pwrite and pwdata hold their last values (no toggling on an idle bus).
  - rsp_valid=1 with all rsp_* stable until rsp_ready=1, then go to IDLE and clear rsp_valid.
- Latency: command accepted at cycle N → SETUP at N+1 → ACCESS at N+2. With zero-wait pready, rsp_valid=1 at N+3. Each wait state adds 1 cycle. Minimum command-to-command spacing is 4 cycles.
- Wait counter: width $clog2(TIMEOUT_CYCLES+1). Cleared on entry to ACCESS; never wraps.
- cmd_* inputs are ignored outside an IDLE handshake.
- rsp_ready is ignored outside RESP.

Decomposition:
- apb_mstr_bridge_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - the command struct (write, addr, wdata, sel);
  - the response struct (rdata, err, timeout);
  - localparam SEL_IDX_WIDTH=4.
- One sub-module, apb_mstr_bridge_wdog: the clear/enable wait counter, emitting an expired pulse; tied off when TIMEOUT_CYCLES=0.

Test Plan:
- Write, cmd_sel=2, addr=0x1000, wdata=0xDEADBEEF, pready=1 immediately → psel=4'b0100 at N+1, penable=1 at N+2, rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read, cmd_sel=0, addr=0x20, pready low for 3 ACCESS cycles, prdata=0xA5A5_0001, pslverr=1 → penable high 4 cycles, rsp_rdata=0xA5A5_0001, rsp_err=1, rsp_timeout=0.
- cmd_sel=7 with NUM_SLV=4 → psel stays 0 throughout; rsp_valid at N+1 with rsp_err=1, rsp_timeout=0.
- TIMEOUT_CYCLES=8, pready held 0 → exactly 8 ACCESS cycles, then psel=0 and rsp_err=1, rsp_timeout=1. Repeat with pready=1 on the 8th cycle → normal completion, rsp_timeout=0.
- rsp_ready held low for 5 cycles while cmd_valid=1 → cmd_ready=0 and rsp_* stable throughout; second command accepted the cycle after rsp_ready=1.
- reset_n=0 during ACCESS → next cycle psel=0, penable=0, rsp_valid=0, cmd_ready=0. After release cmd_ready=1 and no stale response appears.
